// File: rtl/xmac_seq_pkg.sv
// xmac_seq_pkg
//   Shared constants for the X-unit multiply-accumulate sequencer.
//   - ALU Sel codes for the approximate X ops. These values must match the
//     core ALU decoder.
//   - xmac_seq FSM state encodings (3 bits).
package xmac_seq_pkg;

  localparam int LEN_W_DEF = 8;

  localparam logic [3:0] ALU_X_MUL = 4'hA;
  localparam logic [3:0] ALU_X_ADD = 4'hB;

  localparam logic [2:0] XS_IDLE  = 3'd0;
  localparam logic [2:0] XS_FETCH = 3'd1;
  localparam logic [2:0] XS_MUL   = 3'd2;
  localparam logic [2:0] XS_ADD   = 3'd3;
  localparam logic [2:0] XS_DONE  = 3'd4;

endpackage

// File: rtl/xmac_seq.sv
// xmac_seq
//   Multi-cycle multiply-accumulate sequencer for the approximate X-unit.
//   It borrows the shared core ALU through a req/gnt handshake. For each
//   operand pair it issues one X_MUL and then one X_ADD into a running
//   32-bit accumulator.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start_i; len_i and acc_init_i are sampled here
//   FETCH | op_ready_o high, waiting for an operand pair
//   MUL   | requesting the ALU for op_a*op_b, result latched into prod
//   ADD   | requesting the ALU for prod+acc, result latched into acc
//   DONE  | one-cycle done_o pulse, then back to IDLE
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   start_i, len_i           run start (IDLE only) and element count
//   acc_init_i               accumulator seed, sampled with start_i
//   abort_i                  cancel the run; the partial acc is kept
//   op_valid_i/op_ready_o    operand pair handshake (op_a_i, op_b_i)
//   x_req_o/x_gnt_i          ALU sharing handshake
//   alu_a_o/alu_b_o/alu_sel_o/alu_out_i  ALU operands, Sel and result
//   busy_o, done_o, acc_o    status and accumulator
module xmac_seq
  import xmac_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      acc_init_i,
  input  logic             abort_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [15:0]      op_a_i,
  input  logic [15:0]      op_b_i,
  output logic             x_req_o,
  input  logic             x_gnt_i,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic [3:0]       alu_sel_o,
  input  logic [31:0]      alu_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      acc_o
);

  logic [2:0]       state, state_nxt;
  logic [LEN_W-1:0] count;
  logic [15:0]      op_a, op_b;
  logic [31:0]      prod, acc;

  always_comb begin
    state_nxt = state;
    case (state)
      XS_IDLE:  if (start_i) state_nxt = (len_i == '0) ? XS_DONE : XS_FETCH;
      XS_FETCH: if (op_valid_i) state_nxt = XS_MUL;
      XS_MUL:   if (x_gnt_i) state_nxt = XS_ADD;
      XS_ADD:   if (x_gnt_i) state_nxt = (count == LEN_W'(1)) ? XS_DONE : XS_FETCH;
      XS_DONE:  state_nxt = XS_IDLE;
      default:  state_nxt = XS_IDLE;
    endcase
    // abort wins over every handshake outside IDLE
    if (abort_i && (state != XS_IDLE)) state_nxt = XS_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= XS_IDLE;
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      prod  <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == XS_IDLE) && start_i) begin
        acc   <= acc_init_i;
        count <= len_i;
      end
      // abort drops any operand handshake or ALU result of the same cycle
      if (!abort_i) begin
        if ((state == XS_FETCH) && op_valid_i) begin
          op_a <= op_a_i;
          op_b <= op_b_i;
        end
        if ((state == XS_MUL) && x_gnt_i) prod <= alu_out_i;
        if ((state == XS_ADD) && x_gnt_i) begin
          acc   <= alu_out_i;
          count <= count - LEN_W'(1);
        end
      end
    end
  end

  // ALU operands are pure functions of state and registers, so they stay
  // stable across grant stalls and are zero whenever we are not requesting.
  always_comb begin
    x_req_o   = 1'b0;
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_sel_o = '0;
    case (state)
      XS_MUL: begin
        x_req_o   = 1'b1;
        alu_sel_o = ALU_X_MUL;
        alu_a_o   = {16'h0, op_a};
        alu_b_o   = {16'h0, op_b};
      end
      XS_ADD: begin
        x_req_o   = 1'b1;
        alu_sel_o = ALU_X_ADD;
        alu_a_o   = prod;
        alu_b_o   = acc;
      end
      default: ;
    endcase
  end

  assign op_ready_o = (state == XS_FETCH);
  assign busy_o     = (state != XS_IDLE);
  assign done_o     = (state == XS_DONE);
  assign acc_o      = acc;

endmodule

// File: tb/tb_xmac_seq.sv
// tb_xmac_seq
//   Bench for xmac_seq. The ALU is modelled as exact a*b / a+b. A
//   transaction-level model (elements left, step within an element,
//   exact accumulated sum) predicts every output, and these predictions
//   are compared on every falling clock edge. Directed runs pin the model
//   with hand-computed values, then randomized runs follow.
module tb_xmac_seq;
  import xmac_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  len_i = 8'h0;
  logic [31:0] acc_init_i = 32'h0;
  logic        abort_i = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [15:0] op_a_i = 16'h0;
  logic [15:0] op_b_i = 16'h0;
  logic        x_gnt_i = 1'b0;
  logic        op_ready_o, x_req_o, busy_o, done_o;
  logic [31:0] alu_a_o, alu_b_o, alu_out_i, acc_o;
  logic [3:0]  alu_sel_o;

  int n_cmp = 0;
  int n_bad = 0;

  xmac_seq #(.LEN_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .acc_init_i(acc_init_i), .abort_i(abort_i), .op_valid_i(op_valid_i),
    .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .x_req_o(x_req_o), .x_gnt_i(x_gnt_i), .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o), .alu_sel_o(alu_sel_o), .alu_out_i(alu_out_i),
    .busy_o(busy_o), .done_o(done_o), .acc_o(acc_o)
  );

  always #5 clk_i = ~clk_i;

  // exact ALU
  always_comb begin
    alu_out_i = 32'h0;
    if (alu_sel_o == ALU_X_MUL)      alu_out_i = alu_a_o * alu_b_o;
    else if (alu_sel_o == ALU_X_ADD) alu_out_i = alu_a_o + alu_b_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_step: 0 = waiting for an operand pair, 1 = multiply pending, 2 = add pending
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  int          m_step = 0;
  logic [31:0] m_acc = 32'h0, m_a = 32'h0, m_b = 32'h0, m_prod = 32'h0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_step <= 0;
      m_acc <= 32'h0; m_a <= 32'h0; m_b <= 32'h0; m_prod <= 32'h0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_acc <= acc_init_i;
        if (len_i == 8'd0) m_done <= 1'b1;
        else begin
          m_busy <= 1'b1; m_left <= int'(len_i); m_step <= 0;
        end
      end
    end else if (abort_i) begin
      m_busy <= 1'b0;
    end else begin
      case (m_step)
        0: if (op_valid_i) begin
             m_a <= {16'h0, op_a_i}; m_b <= {16'h0, op_b_i}; m_step <= 1;
           end
        1: if (x_gnt_i) begin
             m_prod <= m_a * m_b; m_step <= 2;
           end
        default: if (x_gnt_i) begin
             m_acc <= m_acc + m_prod; m_left <= m_left - 1; m_step <= 0;
             if (m_left == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
           end
      endcase
    end
  end

  logic        e_ready, e_req;
  logic [3:0]  e_sel;
  logic [31:0] e_a, e_b;
  always_comb begin
    e_ready = m_busy && (m_step == 0);
    e_req   = m_busy && (m_step != 0);
    e_sel = 4'h0; e_a = 32'h0; e_b = 32'h0;
    if (m_busy && m_step == 1) begin e_sel = ALU_X_MUL; e_a = m_a; e_b = m_b; end
    if (m_busy && m_step == 2) begin e_sel = ALU_X_ADD; e_a = m_prod; e_b = m_acc; end
  end

  always @(negedge clk_i) begin
    chk("busy",  {31'h0, busy_o},     {31'h0, m_busy || m_done});
    chk("done",  {31'h0, done_o},     {31'h0, m_done});
    chk("ready", {31'h0, op_ready_o}, {31'h0, e_ready});
    chk("req",   {31'h0, x_req_o},    {31'h0, e_req});
    chk("sel",   {28'h0, alu_sel_o},  {28'h0, e_sel});
    chk("alu_a", alu_a_o, e_a);
    chk("alu_b", alu_b_o, e_b);
    chk("acc",   acc_o, m_acc);
  end

  // ---------------- stimulus ----------------
  logic [15:0] pa[16], pb[16];
  int idx = 0;
  int gnt_mode = 0;      // 0 tied high, 1 random, 2 scripted stalls
  bit rnd_valid = 1'b0;
  int mul_stall = 0, add_stall = 0;
  int ready_cnt = 0, req_cnt = 0;
  logic [31:0] st_init = 32'h0;

  // one clock cycle: choose inputs for the current cycle, then advance
  task automatic step();
    logic hs;
    op_a_i = pa[idx]; op_b_i = pb[idx];
    op_valid_i = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (gnt_mode == 0) x_gnt_i = 1'b1;
    else if (gnt_mode == 1) x_gnt_i = ($urandom_range(0, 2) != 0);
    else begin
      x_gnt_i = 1'b1;
      if (x_req_o && alu_sel_o == ALU_X_MUL && mul_stall > 0) begin
        x_gnt_i = 1'b0; mul_stall--;
        chk("stall_mul_a", alu_a_o, {16'h0, pa[0]});
        chk("stall_mul_b", alu_b_o, {16'h0, pb[0]});
      end
      if (x_req_o && alu_sel_o == ALU_X_ADD && add_stall > 0) begin
        x_gnt_i = 1'b0; add_stall--;
        chk("stall_add_a", alu_a_o, 32'(pa[0]) * 32'(pb[0]));
        chk("stall_add_b", alu_b_o, st_init);
      end
    end
    hs = op_ready_o && op_valid_i && !abort_i;
    if (op_ready_o) ready_cnt++;
    if (x_req_o) req_cnt++;
    @(posedge clk_i); #1;
    if (hs && idx < 15) idx++;
  endtask

  // start a run and step until done_o; total = start cycle .. DONE cycle
  task automatic run(input logic [7:0] len, input logic [31:0] init,
                     input int maxc, input bit poke, output int total);
    int cyc;
    start_i = 1'b1; len_i = len; acc_init_i = init; st_init = init;
    idx = 0; ready_cnt = 0; req_cnt = 0;
    step();
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < maxc) begin
      if (poke && cyc == 3) begin
        start_i = 1'b1; len_i = 8'd5; acc_init_i = 32'd999;
      end else start_i = 1'b0;
      step();
      cyc++;
    end
    start_i = 1'b0;
    if (!done_o) chk("run_timeout", 32'h0, 32'h1);
    total = cyc + 1;
    step();
    chk("done_one_cycle", {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    int total;
    int guard;
    int adds;
    int l;
    for (int i = 0; i < 16; i++) begin pa[i] = 16'h0; pb[i] = 16'h0; end

    @(posedge clk_i); #1;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_acc", acc_o, 32'h0);
    chk("rst_req", {31'h0, x_req_o}, 32'h0);
    chk("rst_sel", {28'h0, alu_sel_o}, 32'h0);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // len=2, (3,5),(2,4): 15+8 = 23, 8-cycle run, two operand accepts
    gnt_mode = 0; rnd_valid = 1'b0;
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd2; pb[1] = 16'd4;
    run(8'd2, 32'h0, 50, 1'b0, total);
    chk("len2_cycles", total, 32'd8);
    chk("len2_acc", acc_o, 32'd23);
    chk("len2_ready_cnt", ready_cnt, 32'd2);

    // len=0: straight to DONE, seed passes through, no ALU request
    run(8'd0, 32'h1234, 10, 1'b0, total);
    chk("len0_cycles", total, 32'd2);
    chk("len0_acc", acc_o, 32'h1234);
    chk("len0_req_cnt", req_cnt, 32'd0);

    // grant stalls: 4 in MUL, 3 in ADD -> 1+3+7+1 = 12 cycles, 7*9 = 63
    gnt_mode = 2; mul_stall = 4; add_stall = 3;
    pa[0] = 16'd7; pb[0] = 16'd9;
    run(8'd1, 32'h0, 50, 1'b0, total);
    chk("stall_cycles", total, 32'd12);
    chk("stall_acc", acc_o, 32'd63);
    chk("stall_used", mul_stall + add_stall, 32'd0);

    // wrap: 0xFFFFFFF0 + 32 = 0x10
    gnt_mode = 0;
    pa[0] = 16'd4; pb[0] = 16'd8;
    run(8'd1, 32'hFFFF_FFF0, 50, 1'b0, total);
    chk("wrap_acc", acc_o, 32'h0000_0010);

    // abort in the second ADD cycle with grant: acc keeps only 3*5
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd2; pb[1] = 16'd4;
    pa[2] = 16'd6; pb[2] = 16'd6;
    start_i = 1'b1; len_i = 8'd3; acc_init_i = 32'h0; idx = 0;
    step();
    start_i = 1'b0;
    adds = 0; guard = 0;
    while (adds < 2 && guard < 40) begin
      step();
      guard++;
      if (x_req_o && alu_sel_o == ALU_X_ADD) adds++;
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", {31'h0, busy_o}, 32'h0);
    chk("abort_done", {31'h0, done_o}, 32'h0);
    chk("abort_acc", acc_o, 32'd15);
    step();
    chk("abort_done_later", {31'h0, done_o}, 32'h0);
    chk("abort_acc_hold", acc_o, 32'd15);
    pa[0] = 16'd10; pb[0] = 16'd10;
    run(8'd1, 32'd1, 50, 1'b0, total);
    chk("after_abort_acc", acc_o, 32'd101);

    // reset dropped while in MUL
    pa[0] = 16'd3; pb[0] = 16'd5; pa[1] = 16'd2; pb[1] = 16'd4;
    start_i = 1'b1; len_i = 8'd2; acc_init_i = 32'h55; idx = 0;
    step();
    start_i = 1'b0;
    guard = 0;
    while (!(x_req_o && alu_sel_o == ALU_X_MUL) && guard < 10) begin
      step(); guard++;
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_req", {31'h0, x_req_o}, 32'h0);
    chk("arst_sel", {28'h0, alu_sel_o}, 32'h0);
    chk("arst_a", alu_a_o, 32'h0);
    chk("arst_b", alu_b_o, 32'h0);
    chk("arst_acc", acc_o, 32'h0);
    @(posedge clk_i); #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // normal run after release, with a start pulse mid-run that must be ignored
    run(8'd2, 32'd100, 50, 1'b1, total);
    chk("post_rst_cycles", total, 32'd8);
    chk("post_rst_acc", acc_o, 32'd123);

    // randomized runs: random operands, lengths, valid gaps, grants, aborts
    gnt_mode = 1; rnd_valid = 1'b1;
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 16; i++) begin
        pa[i] = 16'($urandom_range(0, 65535));
        pb[i] = 16'($urandom_range(0, 65535));
      end
      l = $urandom_range(0, 6);
      start_i = 1'b1; len_i = 8'(l); acc_init_i = $urandom; idx = 0;
      step();
      start_i = 1'b0;
      guard = 0;
      while (busy_o && guard < 400) begin
        abort_i = ($urandom_range(0, 39) == 0);
        step();
        guard++;
      end
      abort_i = 1'b0;
      if (busy_o) chk("rnd_timeout", 32'h0, 32'h1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
